sw_btn_ctrl: RTL and testbench
==============================

Name: sw_btn_ctrl

Overview:
- Memory-mapped input peripheral; the CPU reads board inputs through it, the read-side counterpart of the write-only display controller.
- Samples 16 slide switches and 5 push-buttons: synchronises, debounces, latches rising edges into a pending register, raises a maskable interrupt.
- Sits on the core's data-memory bus next to the display controller.

Parameters:
- DEBOUNCE_CYCLES, 100000, clock cycles between debounce sample ticks (1 ms at 100 MHz); minimum 2.
- N_SW, 16, number of switch inputs.
- N_BTN, 5, number of button inputs.

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  asynchronous active-low reset
- sw_i  in  N_SW  raw switch pins, asynchronous
- btn_i  in  N_BTN  raw button pins, asynchronous
- req_i  in  1  bus access strobe, one cycle per access
- we_i  in  1  1 = write, 0 = read
- addr_i  in  32  byte address; only [3:2] decoded
- be_i  in  4  byte enables for writes
- wdata_i  in  32  write data
- rdata_o  out  32  read data
- irq_o  out  1  level interrupt request

Behaviour:
- Clocking and reset: one clock, clk_i. rst_ni is asynchronous and active-low. While rst_ni = 0, all flops clear: rdata_o = 0, irq_o = 0, debounced state = 0, pending = 0, enable = 0, prescaler = 0.
- Input synchroniser: two-flop synchroniser per input bit. The combined vector is in_s = {btn, sw}, N_SW + N_BTN = 21 bits.
- Prescaler:
  - Counts 0..DEBOUNCE_CYCLES-1 and wraps to 0.
  - tick = 1 for one cycle when the count equals DEBOUNCE_CYCLES-1.
- Debounce, on each tick:
  - samp <= in_s.
  - For each bit where in_s == samp (the value is stable across two consecutive ticks), db <= in_s. Other bits of db hold.
- Pending register:
  - A bit is set on the cycle after db goes 0->1 (rising edge of the debounced value). Falling edges are ignored.
  - Cleared by writing 1 to that bit at offset 0x4 (write-1-to-clear).
  - If a set and a clear hit the same bit in the same cycle, set wins.
- Interrupt: irq_o is registered: irq_o <= |(pend & en).
- Register map (addr_i[3:2]):
  - 0x0 DATA, read-only: {11'b0, db[20:16] (btn), db[15:0] (sw)}. Writes are ignored.
  - 0x4 PEND, read / W1C, bits [20:0].
  - 0x8 IRQ_EN, read/write, bits [20:0].
  - 0xC reserved: reads 0, writes ignored.
  - Bits [31:21] read 0 in every register.
- Writes:
  - Take effect when req_i & we_i.
  - A byte lane is updated only if its be_i bit is set. For IRQ_EN the byte is written; for PEND a 1 in that byte clears the bit.
  - be_i = 0 means no effect.
- Reads:
  - On req_i & ~we_i, rdata_o is registered the next cycle (1-cycle read latency).
  - rdata_o holds its last value until the next read.
  - A read never modifies state.
- Latency, pin to db: worst case 2 sync cycles + 2*DEBOUNCE_CYCLES + 1. Add 1 cycle to pend and 1 more to irq_o.
- Glitch rejection: a pin pulse seen by only one tick sample never reaches db.
- Reset mid-operation: asynchronous clear; the first tick after release happens at prescaler count DEBOUNCE_CYCLES-1.

Decomposition:
- Package sw_btn_pkg:
  - Offset constants: DATA_OFF = 2'd0, PEND_OFF = 2'd1, IEN_OFF = 2'd2.
  - Width localparams: N_IN = N_SW + N_BTN.
- One sub-module, sw_debounce: parameterised width and DEBOUNCE_CYCLES; contains the synchroniser, prescaler and two-sample debounce; outputs db. The bus and register logic stay in the top.

Test Plan:
- Reset and defaults (DEBOUNCE_CYCLES = 4): assert rst_ni = 0 mid-run -> rdata_o, irq_o, db, pend, en all 0 immediately; after release, read 0x0/0x4/0x8 -> all 0x00000000.
- Switch read: drive sw_i = 16'hA5C3 and wait 12 cycles, then read 0x0 -> rdata_o = 32'h0000A5C3 exactly one cycle after req_i.
- Glitch rejection: pulse btn_i[0] high for 1 cycle straddling a tick -> DATA[16] stays 0, PEND stays 0, irq_o stays 0.
- Interrupt path:
  - Write 0x8 = 32'h00010000 with be_i = 4'b0100.
  - Hold btn_i[0] = 1 → PEND = 32'h00010000 and irq_o rises.
  - Write 0x4 = 32'h00010000 → irq_o falls 2 cycles later.
- Masking and W1C byte lanes:
  - sw_i[3] rising with en = 0 → PEND[3] = 1 and irq_o = 0.
  - Write 0x4 = 32'hFFFFFFFF with be_i = 4'b0010 → PEND[3] stays 1.
  - Same write with be_i = 4'b0001 → PEND = 0.
- Set/clear collision: time a W1C of PEND[5] on the exact cycle a rising edge of db[5] sets it -> PEND[5] = 1 afterwards.

Source files
------------

// File: rtl/sw_btn_pkg.sv
// Shared definitions for the switch/button input peripheral:
// register offsets, default input widths and a byte-enable mask helper.
package sw_btn_pkg;

    localparam int unsigned N_SW_DEF  = 16;
    localparam int unsigned N_BTN_DEF = 5;
    localparam int unsigned N_IN      = N_SW_DEF + N_BTN_DEF;

    // Word offsets decoded from addr_i[3:2]
    typedef enum logic [1:0] {
        DATA_OFF = 2'd0,
        PEND_OFF = 2'd1,
        IEN_OFF  = 2'd2,
        RSVD_OFF = 2'd3
    } reg_off_e;

    function automatic logic [31:0] be_mask(input logic [3:0] be);
        logic [31:0] m;
        m = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            m[i*8 +: 8] = {8{be[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/sw_debounce.sv
// Two-flop synchroniser, tick prescaler and two-sample debounce for a
// vector of asynchronous board inputs.
module sw_debounce
    import sw_btn_pkg::*;
#(
    parameter int unsigned WIDTH           = N_IN,
    parameter int unsigned DEBOUNCE_CYCLES = 100000
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] in_i,
    output logic [WIDTH-1:0] db_o
);

    localparam int unsigned         CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]    CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] r_samp;
    logic [WIDTH-1:0] r_db;
    logic [CNT_W-1:0] r_cnt;
    logic             w_tick;
    logic [WIDTH-1:0] w_stable;

    assign w_tick   = (r_cnt == CNT_MAX);
    // A bit is accepted only when two consecutive tick samples agree
    assign w_stable = ~(r_sync2 ^ r_samp);
    assign db_o     = r_db;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_samp  <= '0;
            r_db    <= '0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= in_i;
            r_sync2 <= r_sync1;
            r_cnt   <= w_tick ? '0 : r_cnt + 1'b1;
            if (w_tick) begin
                r_samp <= r_sync2;
                r_db   <= (r_sync2 & w_stable) | (r_db & ~w_stable);
            end
        end
    end

endmodule

// File: rtl/sw_btn_ctrl.sv
// Memory-mapped switch/button peripheral: debounced input readback,
// rising-edge pending register (W1C) and a maskable level interrupt.
module sw_btn_ctrl
    import sw_btn_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 100000,
    parameter int unsigned N_SW            = N_SW_DEF,
    parameter int unsigned N_BTN           = N_BTN_DEF
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [N_SW-1:0]  sw_i,
    input  logic [N_BTN-1:0] btn_i,
    input  logic             req_i,
    input  logic             we_i,
    input  logic [31:0]      addr_i,
    input  logic [3:0]       be_i,
    input  logic [31:0]      wdata_i,
    output logic [31:0]      rdata_o,
    output logic             irq_o
);

    localparam int unsigned W_IN = N_SW + N_BTN;

    logic [W_IN-1:0] w_db;
    logic [W_IN-1:0] r_db_prev;
    logic [W_IN-1:0] w_rise;
    logic [W_IN-1:0] r_pend;
    logic [W_IN-1:0] r_en;
    logic [W_IN-1:0] w_clr;
    logic [W_IN-1:0] w_wmask;
    logic [W_IN-1:0] w_wdata;
    logic [31:0]     w_mask32;
    logic [31:0]     w_rd_val;
    logic [31:0]     r_rdata;
    logic            r_irq;
    logic            w_wr;
    logic            w_rd;
    reg_off_e        w_off;
    logic            w_unused;

    sw_debounce #(
        .WIDTH           (W_IN),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .in_i   ({btn_i, sw_i}),
        .db_o   (w_db)
    );

    assign w_off    = reg_off_e'(addr_i[3:2]);
    assign w_wr     = req_i & we_i;
    assign w_rd     = req_i & ~we_i;
    assign w_mask32 = be_mask(be_i);
    assign w_wmask  = w_mask32[W_IN-1:0];
    assign w_wdata  = wdata_i[W_IN-1:0];
    assign w_rise   = w_db & ~r_db_prev;
    assign w_unused = ^{addr_i[31:4], addr_i[1:0], wdata_i[31:W_IN], w_mask32[31:W_IN]};

    always_comb begin
        w_clr = '0;
        if (w_wr && (w_off == PEND_OFF)) begin
            w_clr = w_wdata & w_wmask;
        end
    end

    always_comb begin
        w_rd_val = '0;
        unique case (w_off)
            DATA_OFF: w_rd_val = 32'(w_db);
            PEND_OFF: w_rd_val = 32'(r_pend);
            IEN_OFF:  w_rd_val = 32'(r_en);
            RSVD_OFF: w_rd_val = '0;
            default:  w_rd_val = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_db_prev <= '0;
            r_pend    <= '0;
            r_en      <= '0;
            r_irq     <= 1'b0;
            r_rdata   <= '0;
        end else begin
            r_db_prev <= w_db;
            // Set is applied after clear so a same-cycle edge wins
            r_pend    <= (r_pend & ~w_clr) | w_rise;
            if (w_wr && (w_off == IEN_OFF)) begin
                r_en <= (r_en & ~w_wmask) | (w_wdata & w_wmask);
            end
            r_irq     <= |(r_pend & r_en);
            if (w_rd) begin
                r_rdata <= w_rd_val;
            end
        end
    end

    assign rdata_o = r_rdata;
    assign irq_o   = r_irq;

endmodule

// File: tb/tb_sw_btn_ctrl.sv
// Directed self-checking bench for sw_btn_ctrl with a short debounce period.
module tb_sw_btn_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic [15:0] sw_i = '0;
    logic [4:0]  btn_i = '0;
    logic        req_i = 1'b0;
    logic        we_i = 1'b0;
    logic [31:0] addr_i = '0;
    logic [3:0]  be_i = '0;
    logic [31:0] wdata_i = '0;
    logic [31:0] rdata_o;
    logic        irq_o;

    int n_cmp = 0;
    int n_bad = 0;

    sw_btn_ctrl #(
        .DEBOUNCE_CYCLES (4),
        .N_SW            (16),
        .N_BTN           (5)
    ) u_dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .sw_i    (sw_i),
        .btn_i   (btn_i),
        .req_i   (req_i),
        .we_i    (we_i),
        .addr_i  (addr_i),
        .be_i    (be_i),
        .wdata_i (wdata_i),
        .rdata_o (rdata_o),
        .irq_o   (irq_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        req_i = 1'b1; we_i = 1'b1; addr_i = a; wdata_i = d; be_i = be;
        @(posedge clk_i); #1;
        req_i = 1'b0; we_i = 1'b0; be_i = '0; wdata_i = '0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        req_i = 1'b1; we_i = 1'b0; addr_i = a;
        @(posedge clk_i); #1;
        req_i = 1'b0;
        d = rdata_o;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    initial begin
        logic [31:0] rd;
        logic        seen;

        // Power-on reset
        #1;
        check("por_rdata", rdata_o, 32'h0);
        check("por_irq", 32'(irq_o), 32'h0);
        cycles(3);
        rst_ni = 1'b1;
        cycles(1);
        bus_read(32'h0, rd); check("rst_data", rd, 32'h0);
        bus_read(32'h4, rd); check("rst_pend", rd, 32'h0);
        bus_read(32'h8, rd); check("rst_ien", rd, 32'h0);
        bus_read(32'hC, rd); check("rsvd_read", rd, 32'h0);

        // Switch readback and rising edges into PEND
        sw_i = 16'hA5C3;
        cycles(12);
        bus_read(32'h0, rd); check("sw_data", rd, 32'h0000A5C3);
        cycles(3);
        check("rdata_hold", rdata_o, 32'h0000A5C3);
        bus_read(32'h4, rd); check("sw_pend", rd, 32'h0000A5C3);
        check("sw_irq_masked", 32'(irq_o), 32'h0);
        bus_write(32'h4, 32'hFFFFFFFF, 4'b1111);
        bus_read(32'h4, rd); check("pend_clr_all", rd, 32'h0);

        // Single-cycle glitches at all four prescaler phases
        for (int p = 0; p < 4; p++) begin
            btn_i[0] = 1'b1;
            cycles(1);
            btn_i[0] = 1'b0;
            cycles(12 + p);
        end
        bus_read(32'h0, rd); check("glitch_data", rd, 32'h0000A5C3);
        bus_read(32'h4, rd); check("glitch_pend", rd, 32'h0);
        check("glitch_irq", 32'(irq_o), 32'h0);

        // Interrupt path on btn[0]
        bus_write(32'h8, 32'h00010000, 4'b0100);
        bus_read(32'h8, rd); check("ien_b16", rd, 32'h00010000);
        btn_i[0] = 1'b1;
        cycles(16);
        bus_read(32'h4, rd); check("btn_pend", rd, 32'h00010000);
        check("btn_irq", 32'(irq_o), 32'h1);
        bus_write(32'h4, 32'h00010000, 4'b0100);
        check("irq_after_w1c_1", 32'(irq_o), 32'h1);
        cycles(1);
        check("irq_after_w1c_2", 32'(irq_o), 32'h0);
        bus_read(32'h4, rd); check("btn_pend_clr", rd, 32'h0);
        btn_i[0] = 1'b0;
        cycles(16);
        bus_read(32'h4, rd); check("fall_ignored", rd, 32'h0);
        bus_read(32'h0, rd); check("btn_released", rd, 32'h0000A5C3);

        // Masking and W1C byte lanes on sw[3]
        sw_i = 16'hA5CB;
        cycles(16);
        bus_read(32'h4, rd); check("sw3_pend", rd, 32'h00000008);
        check("sw3_irq_masked", 32'(irq_o), 32'h0);
        bus_write(32'h4, 32'hFFFFFFFF, 4'b0010);
        bus_read(32'h4, rd); check("w1c_wrong_lane", rd, 32'h00000008);
        bus_write(32'h4, 32'hFFFFFFFF, 4'b0001);
        bus_read(32'h4, rd); check("w1c_lane0", rd, 32'h0);

        // Write side effects and register widths
        bus_write(32'h8, 32'hFFFFFFFF, 4'b0000);
        bus_read(32'h8, rd); check("ien_be0", rd, 32'h00010000);
        bus_write(32'h0, 32'hFFFFFFFF, 4'b1111);
        bus_read(32'h0, rd); check("data_ro", rd, 32'h0000A5CB);
        bus_write(32'hC, 32'hFFFFFFFF, 4'b1111);
        bus_read(32'hC, rd); check("rsvd_wr", rd, 32'h0);
        bus_write(32'h8, 32'hFFFFFFFF, 4'b1111);
        bus_read(32'h8, rd); check("ien_width", rd, 32'h001FFFFF);
        check("ien_all_no_pend_irq", 32'(irq_o), 32'h0);
        bus_write(32'h8, 32'h0, 4'b1111);

        // Set/clear collision on pend[5]
        sw_i = 16'hA5EB;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk_i); #1;
            if (u_dut.w_db[5]) begin
                seen = 1'b1;
                break;
            end
        end
        check("db5_seen", 32'(seen), 32'h1);
        bus_write(32'h4, 32'h00000020, 4'b0001);
        bus_read(32'h4, rd); check("collision_set_wins", rd, 32'h00000020);

        // Mid-run asynchronous reset with irq asserted
        bus_write(32'h8, 32'h00000020, 4'b0001);
        cycles(2);
        check("pre_rst_irq", 32'(irq_o), 32'h1);
        @(posedge clk_i); #3;
        rst_ni = 1'b0;
        #1;
        check("mid_rst_rdata", rdata_o, 32'h0);
        check("mid_rst_irq", 32'(irq_o), 32'h0);
        check("mid_rst_db", 32'(u_dut.w_db), 32'h0);
        check("mid_rst_pend", 32'(u_dut.r_pend), 32'h0);
        check("mid_rst_en", 32'(u_dut.r_en), 32'h0);
        cycles(2);
        rst_ni = 1'b1;
        bus_read(32'h0, rd); check("post_rst_data", rd, 32'h0);
        bus_read(32'h4, rd); check("post_rst_pend", rd, 32'h0);
        bus_read(32'h8, rd); check("post_rst_ien", rd, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
